// File: rtl/spi_ram_pkg.sv
// rtl/spi_ram_pkg.sv - shared opcodes, FSM states and requester IDs for spi_ram_ctrl
package spi_ram_pkg;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC    = 2'd1,
        RD_CAP = 2'd2
    } state_e;

    localparam logic REQ_SPI  = 1'b0;
    localparam logic REQ_HOST = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter; pointer moves to the loser only on a tie
module rr_arb2 import spi_ram_pkg::*; (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       update_i,
    output logic       gnt_o,
    output logic       any_o
);

    logic ptr_q, ptr_d;

    always_comb begin
        any_o = |req_i;
        if (&req_i) begin
            gnt_o = ptr_q;
        end else if (req_i[REQ_HOST]) begin
            gnt_o = REQ_HOST;
        end else begin
            gnt_o = REQ_SPI;
        end
        ptr_d = ptr_q;
        if (update_i && (&req_i)) begin
            ptr_d = ~gnt_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= REQ_SPI;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/spi_ram_ctrl.sv
// rtl/spi_ram_ctrl.sv - SPI command decoder and RAM port arbiter; SPI_RAM_AUTOINC_EN adds address post-increment
module spi_ram_ctrl import spi_ram_pkg::*; #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              cmd_drop
);

`ifdef SPI_RAM_AUTOINC_EN
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return (a == ADDR_W'(MEM_DEPTH - 1)) ? '0 : a + 1'b1;
    endfunction
`endif

    logic              rx_valid_q;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic              pend_q, pend_d, pend_we_q, pend_we_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [DATA_W-1:0] pend_wdata_q, pend_wdata_d;
    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
    logic              host_rvalid_q, host_rvalid_d;
    logic              cmd_drop_q, cmd_drop_d;

    logic              is_idle, arb_gnt, arb_any, spi_take, rx_edge;
    logic [1:0]        op;
    logic [ADDR_W-1:0] pay_addr;
    logic [DATA_W-1:0] pay_data;

    assign is_idle  = (state_q == IDLE);
    assign rx_edge  = rx_valid & ~rx_valid_q;
    assign op       = rx_data[9:8];
    assign pay_addr = ADDR_W'(rx_data[7:0]);
    assign pay_data = DATA_W'(rx_data[7:0]);
    assign spi_take = is_idle && arb_any && (arb_gnt == REQ_SPI);

    rr_arb2 u_arb (
        .clk_i    (clk),
        .rst_i    (rst),
        .req_i    ({host_req & is_idle, pend_q & is_idle}),
        .update_i (is_idle),
        .gnt_o    (arb_gnt),
        .any_o    (arb_any)
    );

    always_comb begin
        wr_addr_d     = wr_addr_q;
        rd_addr_d     = rd_addr_q;
        pend_d        = pend_q;
        pend_we_d     = pend_we_q;
        pend_addr_d   = pend_addr_q;
        pend_wdata_d  = pend_wdata_q;
        state_d       = state_q;
        owner_d       = owner_q;
        ram_we_d      = ram_we_q;
        ram_addr_d    = ram_addr_q;
        ram_wdata_d   = ram_wdata_q;
        tx_data_d     = tx_data_q;
        tx_valid_d    = 1'b0;
        host_rdata_d  = host_rdata_q;
        host_rvalid_d = 1'b0;
        cmd_drop_d    = 1'b0;

        if (spi_take) begin
            pend_d = 1'b0;
        end

        // The buffer slot freed by a grant this cycle is immediately reusable.
        if (rx_edge) begin
            case (op)
                OP_WR_ADDR: wr_addr_d = pay_addr;
                OP_RD_ADDR: rd_addr_d = pay_addr;
                default: begin
                    if (pend_q && !spi_take) begin
                        cmd_drop_d = 1'b1;
                    end else begin
                        pend_d       = 1'b1;
                        pend_we_d    = (op == OP_WR_DATA);
                        pend_addr_d  = (op == OP_WR_DATA) ? wr_addr_q : rd_addr_q;
                        pend_wdata_d = pay_data;
`ifdef SPI_RAM_AUTOINC_EN
                        if (op == OP_WR_DATA) begin
                            wr_addr_d = next_addr(wr_addr_q);
                        end else begin
                            rd_addr_d = next_addr(rd_addr_q);
                        end
`endif
                    end
                end
            endcase
        end

        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    owner_d = arb_gnt;
                    state_d = ACC;
                    if (arb_gnt == REQ_SPI) begin
                        ram_we_d    = pend_we_q;
                        ram_addr_d  = pend_addr_q;
                        ram_wdata_d = pend_wdata_q;
                    end else begin
                        ram_we_d    = host_we;
                        ram_addr_d  = host_addr;
                        ram_wdata_d = host_wdata;
                    end
                end
            end
            ACC: begin
                state_d = ram_we_q ? IDLE : RD_CAP;
            end
            RD_CAP: begin
                if (owner_q == REQ_SPI) begin
                    tx_data_d  = ram_rdata[7:0];
                    tx_valid_d = 1'b1;
                end else begin
                    host_rdata_d  = ram_rdata;
                    host_rvalid_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_valid_q    <= 1'b0;
            wr_addr_q     <= '0;
            rd_addr_q     <= '0;
            pend_q        <= 1'b0;
            pend_we_q     <= 1'b0;
            pend_addr_q   <= '0;
            pend_wdata_q  <= '0;
            state_q       <= IDLE;
            owner_q       <= REQ_SPI;
            ram_we_q      <= 1'b0;
            ram_addr_q    <= '0;
            ram_wdata_q   <= '0;
            tx_data_q     <= '0;
            tx_valid_q    <= 1'b0;
            host_rdata_q  <= '0;
            host_rvalid_q <= 1'b0;
            cmd_drop_q    <= 1'b0;
        end else begin
            rx_valid_q    <= rx_valid;
            wr_addr_q     <= wr_addr_d;
            rd_addr_q     <= rd_addr_d;
            pend_q        <= pend_d;
            pend_we_q     <= pend_we_d;
            pend_addr_q   <= pend_addr_d;
            pend_wdata_q  <= pend_wdata_d;
            state_q       <= state_d;
            owner_q       <= owner_d;
            ram_we_q      <= ram_we_d;
            ram_addr_q    <= ram_addr_d;
            ram_wdata_q   <= ram_wdata_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            host_rdata_q  <= host_rdata_d;
            host_rvalid_q <= host_rvalid_d;
            cmd_drop_q    <= cmd_drop_d;
        end
    end

    assign ram_en      = (state_q == ACC);
    assign host_gnt    = (state_q == ACC) && (owner_q == REQ_HOST);
    assign ram_we      = ram_we_q;
    assign ram_addr    = ram_addr_q;
    assign ram_wdata   = ram_wdata_q;
    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign host_rdata  = host_rdata_q;
    assign host_rvalid = host_rvalid_q;
    assign cmd_drop    = cmd_drop_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// tb/tb_spi_ram_ctrl.sv - self-checking bench for spi_ram_ctrl with RAM and reference models
module tb_spi_ram_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       host_req = 1'b0;
    logic       host_we = 1'b0;
    logic [7:0] host_addr = '0;
    logic [7:0] host_wdata = '0;
    logic       host_gnt;
    logic [7:0] host_rdata;
    logic       host_rvalid;
    logic       ram_en, ram_we;
    logic [7:0] ram_addr, ram_wdata;
    logic [7:0] ram_rdata = '0;
    logic       cmd_drop;

    always #5 clk = ~clk;

    spi_ram_ctrl #(.ADDR_W(8), .DATA_W(8), .MEM_DEPTH(256)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rdata(host_rdata),
        .host_rvalid(host_rvalid), .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .cmd_drop(cmd_drop)
    );

    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int wr_cnt = 0, rd_cnt = 0, tx_cnt = 0, gnt_cnt = 0, rv_cnt = 0, drop_cnt = 0;
    int rd_en_cyc = 0, tx_cyc = 0, gnt_cyc = 0, rv_cyc = 0;
    logic [7:0] last_wa = '0, last_wd = '0, last_tx = '0, last_hr = '0;
    logic [7:0] wa_q [$];
    int order [$];

    always @(negedge clk) begin
        if (!rst) begin
            if (ram_en) begin
                order.push_back(host_gnt ? 1 : 0);
                if (ram_we) begin
                    wr_cnt++; last_wa = ram_addr; last_wd = ram_wdata; wa_q.push_back(ram_addr);
                end else begin
                    rd_cnt++; rd_en_cyc = cyc;
                end
            end
            if (tx_valid)    begin tx_cnt++; tx_cyc = cyc; last_tx = tx_data; end
            if (host_gnt)    begin gnt_cnt++; gnt_cyc = cyc; end
            if (host_rvalid) begin rv_cnt++; rv_cyc = cyc; last_hr = host_rdata; end
            if (cmd_drop)    drop_cnt++;
        end
    end

    int checks = 0, errors = 0;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: architectural address registers and memory image.
    logic [7:0] ref_mem [256];
    logic [7:0] ref_wr = '0, ref_rd = '0, exp_tx = '0;

    task automatic model_cmd(input logic [1:0] op, input logic [7:0] pay);
        case (op)
            2'b00: ref_wr = pay;
            2'b01: begin
                ref_mem[ref_wr] = pay;
`ifdef SPI_RAM_AUTOINC_EN
                ref_wr = 8'((int'(ref_wr) + 1) % 256);
`endif
            end
            2'b10: ref_rd = pay;
            default: begin
                exp_tx = ref_mem[ref_rd];
`ifdef SPI_RAM_AUTOINC_EN
                ref_rd = 8'((int'(ref_rd) + 1) % 256);
`endif
            end
        endcase
    endtask

    task automatic spi_send(input logic [1:0] op, input logic [7:0] pay);
        @(posedge clk); #1;
        rx_data = {op, pay}; rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        model_cmd(op, pay);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic host_op(input logic we, input logic [7:0] a, input logic [7:0] d);
        int t;
        @(posedge clk); #1;
        host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
        t = 0;
        do begin
            @(negedge clk); t++;
        end while (!host_gnt && t < 20);
        chk("host_gnt_seen", host_gnt, 1);
        @(posedge clk); #1;
        host_req = 1'b0;
        if (we) ref_mem[a] = d;
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({tx_data, tx_valid, host_gnt, host_rdata, host_rvalid,
                    ram_en, ram_we, ram_addr, ram_wdata, cmd_drop});
    endfunction

    initial begin
        int w0, r0, t0, g0, v0, d0, e0;
        logic [7:0] ea, ra, rp;
        logic [1:0] rop;
        for (int i = 0; i < 256; i++) begin mem[i] = '0; ref_mem[i] = '0; end

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", all_outs(), 0);

        // Address load, write, read with latency check
        w0 = wr_cnt; r0 = rd_cnt; t0 = tx_cnt;
        spi_send(2'b00, 8'h12);
        spi_send(2'b01, 8'hA5);
        idle(4);
        chk("t1_wr_count", wr_cnt - w0, 1);
        chk("t1_wr_addr", last_wa, 8'h12);
        chk("t1_wr_data", last_wd, 8'hA5);
        spi_send(2'b10, 8'h12);
        spi_send(2'b11, 8'h00);
        idle(6);
        chk("t1_rd_count", rd_cnt - r0, 1);
        chk("t1_tx_count", tx_cnt - t0, 1);
        chk("t1_tx_data", last_tx, 8'hA5);
        chk("t1_tx_latency", tx_cyc - rd_en_cyc, 2);

        // Held rx_valid level accepted once
        w0 = wr_cnt; d0 = drop_cnt; ea = ref_wr;
        @(posedge clk); #1;
        rx_data = {2'b01, 8'h3C}; rx_valid = 1'b1;
        repeat (20) @(posedge clk);
        #1 rx_valid = 1'b0;
        model_cmd(2'b01, 8'h3C);
        idle(4);
        chk("t2_wr_count", wr_cnt - w0, 1);
        chk("t2_no_drop", drop_cnt - d0, 0);
        chk("t2_wr_addr", last_wa, ea);

        // Round-robin contention
        for (int r = 0; r < 4; r++) begin
            int t;
            order.delete();
            t0 = tx_cnt;
            @(posedge clk); #1;
            rx_data = {2'b11, 8'h00}; rx_valid = 1'b1;
            @(posedge clk); #1;
            rx_valid = 1'b0;
            model_cmd(2'b11, 8'h00);
            host_req = 1'b1; host_we = 1'b1; host_addr = 8'h30; host_wdata = 8'h5C;
            t = 0;
            do begin @(negedge clk); t++; end while (!host_gnt && t < 20);
            chk("t3_host_gnt_seen", host_gnt, 1);
            @(posedge clk); #1 host_req = 1'b0;
            ref_mem[8'h30] = 8'h5C;
            idle(6);
            chk("t3_access_count", order.size(), 2);
            if (order.size() > 0) chk("t3_first_winner", order[0], r % 2);
            chk("t3_tx_data", last_tx, exp_tx);
            chk("t3_tx_count", tx_cnt - t0, 1);
        end

        // Host write then read
        g0 = gnt_cnt; v0 = rv_cnt;
        host_op(1'b1, 8'h40, 8'h77);
        host_op(1'b0, 8'h40, 8'h00);
        idle(4);
        chk("t4_gnt_count", gnt_cnt - g0, 2);
        chk("t4_rvalid_count", rv_cnt - v0, 1);
        chk("t4_rvalid_latency", rv_cyc - gnt_cyc, 2);
        chk("t4_rdata", last_hr, 8'h77);

        // Drop while buffer is full during a host read
        w0 = wr_cnt; d0 = drop_cnt; ea = ref_wr;
        @(posedge clk); #1;
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h40;
        rx_data = {2'b01, 8'h11}; rx_valid = 1'b1;
        @(posedge clk); #1 rx_valid = 1'b0;
        @(posedge clk); #1;
        host_req = 1'b0;
        rx_data = {2'b01, 8'h22}; rx_valid = 1'b1;
        @(posedge clk); #1 rx_valid = 1'b0;
        model_cmd(2'b01, 8'h11);
        idle(5);
        chk("t5_drop_count", drop_cnt - d0, 1);
        chk("t5_wr_count", wr_cnt - w0, 1);
        chk("t5_wr_addr", last_wa, ea);
        chk("t5_wr_data", last_wd, 8'h11);

`ifdef SPI_RAM_AUTOINC_EN
        spi_send(2'b00, 8'hFF);
        wa_q.delete();
        spi_send(2'b01, 8'hB1);
        idle(4);
        spi_send(2'b01, 8'hB2);
        idle(4);
        chk("t5_wrap_count", wa_q.size(), 2);
        if (wa_q.size() == 2) begin
            chk("t5_wrap_first", wa_q[0], 8'hFF);
            chk("t5_wrap_second", wa_q[1], 8'h00);
        end
`endif

        // Reset during RD_CAP
        t0 = tx_cnt; r0 = rd_cnt;
        @(posedge clk); #1;
        rx_data = {2'b11, 8'h00}; rx_valid = 1'b1;
        @(posedge clk); #1 rx_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t6_reset_outputs", all_outs(), 0);
        @(posedge clk); #1 rst = 1'b0;
        ref_wr = '0; ref_rd = '0;
        e0 = wr_cnt + rd_cnt;
        idle(8);
        chk("t6_read_started", rd_cnt - r0, 1);
        chk("t6_no_tx", tx_cnt - t0, 0);
        chk("t6_no_pending_access", wr_cnt + rd_cnt - e0, 0);

        // Randomised SPI and host traffic against the reference model
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 4) begin
                ra = 8'($urandom_range(0, 255));
                rp = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 1) == 1) begin
                    host_op(1'b1, ra, rp);
                    idle(2);
                end else begin
                    v0 = rv_cnt;
                    ea = ref_mem[ra];
                    host_op(1'b0, ra, 8'h00);
                    idle(4);
                    chk("rnd_host_rvalid", rv_cnt - v0, 1);
                    chk("rnd_host_rdata", last_hr, ea);
                end
            end else begin
                rop = 2'($urandom_range(0, 3));
                rp  = 8'($urandom_range(0, 255));
                t0 = tx_cnt; w0 = wr_cnt; ea = ref_wr;
                spi_send(rop, rp);
                idle(5);
                if (rop == 2'b11) begin
                    chk("rnd_tx_count", tx_cnt - t0, 1);
                    chk("rnd_tx_data", last_tx, exp_tx);
                end else if (rop == 2'b01) begin
                    chk("rnd_wr_count", wr_cnt - w0, 1);
                    chk("rnd_wr_addr", last_wa, ea);
                    chk("rnd_wr_data", last_wd, rp);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
